div_share_arbiter: RTL and testbench
====================================

Name: div_share_arbiter

Overview:
- Shares the single 8-bit unsigned divider (a/b/vld -> quo/rem/ack) among the TFE averaging-feature requesters: pps, bps, average packet size and average inter-arrival.
- Round-robin arbitration; one division in flight at a time.
- Divide-by-zero is bypassed locally, and a watchdog returns an error if the divider never acks.
- Sits between the feature-update logic and the divider instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 8, operand/result width; must match the divider.
- TIMEOUT, 64, cycles spent in WAIT without div_ack before abort (2..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester request level; operands held stable while high.
- req_a  input  N_REQ*W  dividends; requester i occupies bits [i*W +: W].
- req_b  input  N_REQ*W  divisors, same packing.
- done  output  N_REQ  one-hot, one-cycle pulse: result for requester i valid.
- res_quo  output  W  quotient, valid while done!=0.
- res_rem  output  W  remainder, valid while done!=0.
- res_err  output  1  valid while done!=0; 1 = divide-by-zero or timeout.
- busy  output  1  high when state != IDLE.
- div_a  output  W  divider dividend.
- div_b  output  W  divider divisor.
- div_vld  output  1  one-cycle start pulse to divider.
- div_quo  input  W  divider quotient.
- div_rem  input  W  divider remainder.
- div_ack  input  1  divider completion pulse.

Behaviour:
- All outputs are registered. Reset values:
  - done=0, res_quo=0, res_rem=0, res_err=0, busy=0.
  - div_a=0, div_b=0, div_vld=0.
  - state=IDLE, rr_ptr=0, tmo_cnt=0.
- FSM states IDLE, ISSUE, WAIT, RESP:
  - IDLE, no req: stay.
  - IDLE, any req: pick the first set bit of req searching from rr_ptr upward with wrap. Latch idx and that requester's a/b into div_a/div_b.
    - If b==0: latch res_quo={W{1}}, res_rem=a, res_err=1, go RESP. The divider is not started.
    - Else: go ISSUE.
  - ISSUE: div_vld=1 for exactly this cycle; clear tmo_cnt; go WAIT.
  - WAIT: div_a/div_b held stable.
    - If div_ack: latch res_quo=div_quo, res_rem=div_rem, res_err=0, go RESP.
    - Else if tmo_cnt==TIMEOUT-1: latch res_quo={W{1}}, res_rem={W{1}}, res_err=1, go RESP.
    - Else: tmo_cnt++.
    - div_ack and timeout in the same cycle: ack wins.
  - RESP: done[idx]=1 for one cycle; rr_ptr <= (idx+1) mod N_REQ; go IDLE.
- Latency:
  - Normal path: req sampled in IDLE at cycle 0; div_vld at cycle 1; done one cycle after the div_ack cycle.
  - Divide-by-zero path: done at cycle 1.
  - Minimum spacing between consecutive grants is 1 idle cycle (RESP->IDLE).
- Requester handshake:
  - Requester holds req and operands until its done pulse, then deasserts req on the next cycle.
  - req still high in the IDLE cycle after done is treated as a new request.
  - Because rr_ptr has advanced, other pending requesters are served first.
  - req dropped before done: the operation completes and done still pulses. The requester ignores it.
- Operands are captured only in IDLE. Changes on req_a/req_b afterwards do not affect the in-flight operation.
- div_ack outside WAIT (stray or late after timeout) is ignored; no state change.
- Fairness: with all requesters continuously requesting, service order is 0,1,...,N_REQ-1,0,... No requester waits more than N_REQ-1 operations.
- Reset asserted mid-operation: immediate return to the reset state.
  - No done is issued for the aborted operation.
  - div_vld is forced low.
  - A subsequent div_ack from the divider is ignored by the WAIT-only rule.

Test Plan:
- Single request: req=0001, a=200, b=7 -> div_vld pulse carrying a=200, b=7; after div_ack: done=0001, quo=28, rem=4, err=0.
- Divide by zero: req=0100, a=55, b=0 -> no div_vld; done=0100 one cycle after grant; quo=255, rem=55, err=1.
- Contention: req=1111 held, each requester deasserts for one cycle after its done -> grant order 0,1,2,3,0.
  - Each done matches its operands: (100,10)->10 r0; (9,4)->2 r1; (255,16)->15 r15; (3,5)->0 r3.
- Timeout: divider model never acks, TIMEOUT=64 -> done exactly 64 WAIT cycles after ISSUE; quo=255, rem=255, err=1.
  - A late div_ack injected afterwards -> no effect; next request is served normally.
- Reset mid-WAIT: assert rst_n=0 while waiting -> all outputs 0, busy=0.
  - After release, req=0010, a=81, b=9 -> quo=9, rem=0; rr_ptr restarts from requester 0.
- Ack/timeout collision: div_ack arrives on the timeout cycle -> divider result returned, err=0.

Source files
------------

// File: rtl/div_share_arbiter.sv
// Round-robin front end that shares one W-bit unsigned divider among N_REQ
// requesters. One division is in flight at a time. A zero divisor is answered
// locally, and a watchdog answers with an error if the divider never acks.
module div_share_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned W       = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   done,
  output logic [W-1:0]       res_quo,
  output logic [W-1:0]       res_rem,
  output logic               res_err,
  output logic               busy,
  output logic [W-1:0]       div_a,
  output logic [W-1:0]       div_b,
  output logic               div_vld,
  input  logic [W-1:0]       div_quo,
  input  logic [W-1:0]       div_rem,
  input  logic               div_ack
);

  localparam int unsigned IdxW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0]  TmoLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [7:0]      tmo_cnt_q, tmo_cnt_d;

  logic [N_REQ-1:0] done_q, done_d;
  logic [W-1:0]     quo_q, quo_d;
  logic [W-1:0]     rem_q, rem_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic [W-1:0]     div_a_q, div_a_d;
  logic [W-1:0]     div_b_q, div_b_d;
  logic             vld_q, vld_d;

  logic [W-1:0]     a_arr [N_REQ];
  logic [W-1:0]     b_arr [N_REQ];
  logic             grant_vld;
  logic [IdxW-1:0]  grant_idx;
  int unsigned      cand;
  logic [W-1:0]     sel_a;
  logic [W-1:0]     sel_b;
  logic             tmo_hit;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*W +: W];
    assign b_arr[i] = req_b[i*W +: W];
  end

  // Round-robin pick: first requester at or after rr_ptr, wrapping around.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!grant_vld && req[cand[IdxW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[IdxW-1:0];
      end
    end
  end

  assign sel_a   = a_arr[grant_idx];
  assign sel_b   = b_arr[grant_idx];
  assign tmo_hit = (tmo_cnt_q == TmoLast);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant_vld) state_d = (sel_b == '0) ? StResp : StIssue;
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (div_ack || tmo_hit) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and bookkeeping.
  always_comb begin
    idx_d     = idx_q;
    rr_ptr_d  = rr_ptr_q;
    tmo_cnt_d = tmo_cnt_q;
    div_a_d   = div_a_q;
    div_b_d   = div_b_q;
    vld_d     = 1'b0;
    done_d    = '0;
    quo_d     = quo_q;
    rem_d     = rem_q;
    err_d     = err_q;
    busy_d    = (state_d != StIdle);
    unique case (state_q)
      StIdle: begin
        if (grant_vld) begin
          idx_d   = grant_idx;
          div_a_d = sel_a;
          div_b_d = sel_b;
          if (sel_b == '0) begin
            // Divide-by-zero answered locally; the divider is never started.
            quo_d             = '1;
            rem_d             = sel_a;
            err_d             = 1'b1;
            done_d[grant_idx] = 1'b1;
          end else begin
            vld_d = 1'b1;
          end
        end
      end
      StIssue: tmo_cnt_d = '0;
      StWait: begin
        // An ack on the final watchdog cycle still wins.
        if (div_ack) begin
          quo_d         = div_quo;
          rem_d         = div_rem;
          err_d         = 1'b0;
          done_d[idx_q] = 1'b1;
        end else if (tmo_hit) begin
          quo_d         = '1;
          rem_d         = '1;
          err_d         = 1'b1;
          done_d[idx_q] = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      StResp: begin
        rr_ptr_d = (32'(idx_q) == N_REQ - 1) ? '0 : idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      rr_ptr_q  <= '0;
      tmo_cnt_q <= '0;
      div_a_q   <= '0;
      div_b_q   <= '0;
      vld_q     <= 1'b0;
      done_q    <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      rr_ptr_q  <= rr_ptr_d;
      tmo_cnt_q <= tmo_cnt_d;
      div_a_q   <= div_a_d;
      div_b_q   <= div_b_d;
      vld_q     <= vld_d;
      done_q    <= done_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign done    = done_q;
  assign res_quo = quo_q;
  assign res_rem = rem_q;
  assign res_err = err_q;
  assign busy    = busy_q;
  assign div_a   = div_a_q;
  assign div_b   = div_b_q;
  assign div_vld = vld_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter: directed scenarios followed by a randomized
// phase, all checked against a transaction-level model of the arbiter.
module tb_div_share_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int TMO = 64;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0] done;
  logic [W-1:0] res_quo, res_rem;
  logic         res_err, busy;
  logic [W-1:0] div_a, div_b;
  logic         div_vld;
  logic [W-1:0] div_quo, div_rem;
  logic         div_ack;

  always #5 clk = ~clk;

  div_share_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TMO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .req_a   (req_a),
    .req_b   (req_b),
    .done    (done),
    .res_quo (res_quo),
    .res_rem (res_rem),
    .res_err (res_err),
    .busy    (busy),
    .div_a   (div_a),
    .div_b   (div_b),
    .div_vld (div_vld),
    .div_quo (div_quo),
    .div_rem (div_rem),
    .div_ack (div_ack)
  );

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Requester models.
  bit         req_on [N];
  logic [7:0] op_a [N];
  logic [7:0] op_b [N];
  bit         rearm [N];
  int         relaunch_at [N];
  bit         drop_pend [N];
  bit         drop_set [N];
  bit         auto_mode = 0;
  bit         stray_en = 0;
  int         force_lat = -1;

  // Transaction-level arbiter model.
  int         ptr = 0;
  bit         exp_active = 0;
  bit         exp_zero = 0;
  int         exp_idx = 0, grant_cyc = 0, exp_done_cyc = 0, exp_lat = 0;
  int         last_done_cyc = -1;
  logic [7:0] exp_a, exp_b;

  // Divider stub.
  int         ack_due = -1, late_ack = -1;
  logic [7:0] stub_a, stub_b;

  // Observation log.
  int         done_cnt = 0;
  int         order_q[$];
  logic [7:0] quo_log[$];
  logic [7:0] rem_log[$];
  logic [7:0] obs_quo, obs_rem;
  logic       obs_err;
  int         obs_done_cyc = -1, obs_vld_cyc = -1;

  function automatic int rand_lat();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return TMO;
    if (r == 1) return TMO + 1;
    if (r == 2) return TMO + 2;
    return $urandom_range(1, 6);
  endfunction

  task automatic tick();
    logic [N-1:0] exp_done_v;
    logic [N-1:0] req_v;
    logic         exp_vld_now;
    logic [7:0]   eq, er;
    logic         ee;
    bit           in_wait;
    @(negedge clk);
    cyc++;
    // Compare this cycle's registered outputs with the model.
    exp_done_v  = '0;
    exp_vld_now = 1'b0;
    if (exp_active) begin
      if (!exp_zero && cyc == grant_cyc + 1) exp_vld_now = 1'b1;
      if (cyc == exp_done_cyc) exp_done_v[exp_idx] = 1'b1;
    end
    check("busy", 32'(busy), 32'(exp_active));
    check("done", 32'(done), 32'(exp_done_v));
    check("div_vld", 32'(div_vld), 32'(exp_vld_now));
    if (div_vld === 1'b1) obs_vld_cyc = cyc;
    if (done != '0) begin
      obs_done_cyc = cyc;
      obs_quo = res_quo;
      obs_rem = res_rem;
      obs_err = res_err;
      quo_log.push_back(res_quo);
      rem_log.push_back(res_rem);
    end
    if (exp_vld_now) begin
      check("div_a", 32'(div_a), 32'(exp_a));
      check("div_b", 32'(div_b), 32'(exp_b));
      stub_a = div_a;
      stub_b = div_b;
    end
    if (exp_done_v != '0) begin
      if (exp_zero) begin
        eq = 8'hFF; er = exp_a; ee = 1'b1;
      end else if (exp_lat <= TMO) begin
        eq = exp_a / exp_b; er = exp_a % exp_b; ee = 1'b0;
      end else begin
        eq = 8'hFF; er = 8'hFF; ee = 1'b1;
      end
      check("res_quo", 32'(res_quo), 32'(eq));
      check("res_rem", 32'(res_rem), 32'(er));
      check("res_err", 32'(res_err), 32'(ee));
      order_q.push_back(exp_idx);
      done_cnt++;
      exp_active       = 1'b0;
      ptr              = (exp_idx + 1) % N;
      last_done_cyc    = cyc;
      drop_set[exp_idx] = 1'b1;
    end
    // Requesters drop req the cycle after their done, optionally come back.
    for (int i = 0; i < N; i++) begin
      if (drop_pend[i]) begin
        req_on[i] = 1'b0;
        if (rearm[i]) relaunch_at[i] = cyc + 1 + (auto_mode ? $urandom_range(0, 3) : 0);
      end
      drop_pend[i] = drop_set[i];
      drop_set[i]  = 1'b0;
      if (!req_on[i] && relaunch_at[i] == cyc) begin
        req_on[i]      = 1'b1;
        relaunch_at[i] = -1;
        if (auto_mode) begin
          op_a[i] = 8'($urandom);
          op_b[i] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
        end
      end
      if (auto_mode) begin
        if (req_on[i] && $urandom_range(0, 99) == 0) begin
          req_on[i]      = 1'b0;
          relaunch_at[i] = cyc + $urandom_range(1, 5);
        end
        // Operand churn: must never disturb an operation already granted.
        if ($urandom_range(0, 49) == 0) op_a[i] = 8'($urandom);
      end
      req_v[i] = req_on[i];
      req_a[i*W +: W] = op_a[i];
      req_b[i*W +: W] = op_b[i];
    end
    req = req_v;
    // Grant prediction for an idle arbiter.
    if (rst_n && !exp_active && cyc != last_done_cyc && req_v != '0) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (req_v[(ptr + k) % N]) exp_idx = (ptr + k) % N;
      end
      exp_a      = op_a[exp_idx];
      exp_b      = op_b[exp_idx];
      grant_cyc  = cyc;
      exp_active = 1'b1;
      exp_zero   = (exp_b == 8'd0);
      if (exp_zero) begin
        exp_done_cyc = cyc + 1;
        exp_lat      = 0;
      end else begin
        exp_lat   = (force_lat >= 0) ? force_lat : rand_lat();
        force_lat = -1;
        if (exp_lat <= TMO) begin
          ack_due      = cyc + 1 + exp_lat;
          exp_done_cyc = cyc + 2 + exp_lat;
        end else begin
          late_ack     = cyc + 1 + exp_lat;
          exp_done_cyc = cyc + 2 + TMO;
        end
      end
    end
    in_wait = exp_active && !exp_zero && cyc >= grant_cyc + 2 && cyc < exp_done_cyc;
    // Divider stub; junk on the result bus whenever it is not acking.
    if (cyc == ack_due) begin
      div_ack = 1'b1;
      div_quo = (stub_b == 8'd0) ? 8'hFF : stub_a / stub_b;
      div_rem = (stub_b == 8'd0) ? stub_a : stub_a % stub_b;
    end else begin
      div_ack = (cyc == late_ack) || (stray_en && !in_wait && $urandom_range(0, 7) == 0);
      div_quo = 8'($urandom);
      div_rem = 8'($urandom);
    end
  endtask

  task automatic assert_reset();
    rst_n         = 1'b0;
    exp_active    = 1'b0;
    ptr           = 0;
    ack_due       = -1;
    late_ack      = -1;
    last_done_cyc = -1;
    force_lat     = -1;
    for (int i = 0; i < N; i++) begin
      req_on[i]      = 1'b0;
      rearm[i]       = 1'b0;
      drop_pend[i]   = 1'b0;
      drop_set[i]    = 1'b0;
      relaunch_at[i] = -1;
    end
    req = '0;
  endtask

  function automatic bit model_busy();
    bit b;
    b = exp_active;
    for (int i = 0; i < N; i++) begin
      if (req_on[i] || drop_pend[i] || drop_set[i] || relaunch_at[i] > cyc) b = 1'b1;
    end
    return b;
  endfunction

  task automatic drain();
    for (int k = 0; k < 2000; k++) begin
      if (!model_busy()) break;
      tick();
    end
    tick();
    force_lat = -1;
  endtask

  task automatic run_op(input int i, input logic [7:0] a, input logic [7:0] b, input int lat);
    op_a[i]   = a;
    op_b[i]   = b;
    force_lat = lat;
    rearm[i]  = 1'b0;
    req_on[i] = 1'b1;
    drain();
  endtask

  initial begin
    int target, prev_vld, base;
    req = '0; req_a = '0; req_b = '0;
    div_ack = 1'b0; div_quo = '0; div_rem = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = '0;
      op_b[i] = 8'd1;
    end
    assert_reset();
    repeat (3) tick();
    check("rst_quo", 32'(res_quo), 32'd0);
    check("rst_rem", 32'(res_rem), 32'd0);
    check("rst_err", 32'(res_err), 32'd0);
    check("rst_div_a", 32'(div_a), 32'd0);
    check("rst_div_b", 32'(div_b), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single request: 200 / 7.
    run_op(0, 8'd200, 8'd7, 3);
    check("single_quo", 32'(obs_quo), 32'd28);
    check("single_rem", 32'(obs_rem), 32'd4);
    check("single_err", 32'(obs_err), 32'd0);
    check("single_lat", 32'(obs_done_cyc - obs_vld_cyc), 32'd4);

    // Divide by zero: answered locally, divider untouched.
    prev_vld = obs_vld_cyc;
    run_op(2, 8'd55, 8'd0, -1);
    check("dz_quo", 32'(obs_quo), 32'd255);
    check("dz_rem", 32'(obs_rem), 32'd55);
    check("dz_err", 32'(obs_err), 32'd1);
    check("dz_no_vld", 32'(obs_vld_cyc), 32'(prev_vld));

    // Bring the pointer back to requester 0.
    run_op(3, 8'd17, 8'd3, 2);

    // Contention: all four request, each rests one cycle after its done.
    op_a[0] = 8'd100; op_b[0] = 8'd10;
    op_a[1] = 8'd9;   op_b[1] = 8'd4;
    op_a[2] = 8'd255; op_b[2] = 8'd16;
    op_a[3] = 8'd3;   op_b[3] = 8'd5;
    order_q.delete();
    quo_log.delete();
    rem_log.delete();
    for (int i = 0; i < N; i++) begin
      rearm[i]  = 1'b1;
      req_on[i] = 1'b1;
    end
    target = done_cnt + 5;
    for (int k = 0; k < 2000 && done_cnt < target; k++) tick();
    for (int i = 0; i < N; i++) rearm[i] = 1'b0;
    drain();
    for (int k = 0; k < 5; k++) begin
      check("cont_order", (k < order_q.size()) ? order_q[k] : -1, k % N);
    end
    check("cont_quo2", (quo_log.size() > 2) ? 32'(quo_log[2]) : 32'hFFFF, 32'd15);
    check("cont_rem2", (rem_log.size() > 2) ? 32'(rem_log[2]) : 32'hFFFF, 32'd15);

    // Timeout with a late ack arriving in the response cycle.
    run_op(1, 8'd123, 8'd5, TMO + 1);
    check("tmo_quo", 32'(obs_quo), 32'd255);
    check("tmo_rem", 32'(obs_rem), 32'd255);
    check("tmo_err", 32'(obs_err), 32'd1);
    check("tmo_lat", 32'(obs_done_cyc - obs_vld_cyc), 32'(TMO + 1));
    run_op(3, 8'd50, 8'd6, 2);
    check("post_tmo_quo", 32'(obs_quo), 32'd8);
    check("post_tmo_rem", 32'(obs_rem), 32'd2);

    // Ack lands on the last watchdog cycle: the divider result wins.
    run_op(0, 8'd77, 8'd8, TMO);
    check("coll_quo", 32'(obs_quo), 32'd9);
    check("coll_rem", 32'(obs_rem), 32'd5);
    check("coll_err", 32'(obs_err), 32'd0);
    check("coll_lat", 32'(obs_done_cyc - obs_vld_cyc), 32'(TMO + 1));

    // Reset in the middle of a WAIT, with the pointer sitting at 2.
    run_op(1, 8'd30, 8'd4, 1);
    op_a[2] = 8'd99; op_b[2] = 8'd3;
    force_lat = 200;
    req_on[2] = 1'b1;
    repeat (12) tick();
    base = done_cnt;
    assert_reset();
    late_ack = cyc + 1;
    tick();
    check("mid_rst_quo", 32'(res_quo), 32'd0);
    check("mid_rst_rem", 32'(res_rem), 32'd0);
    check("mid_rst_err", 32'(res_err), 32'd0);
    check("mid_rst_div_a", 32'(div_a), 32'd0);
    check("mid_rst_div_b", 32'(div_b), 32'd0);
    tick();
    rst_n = 1'b1;
    late_ack = cyc + 1;
    repeat (3) tick();
    check("mid_rst_no_done", done_cnt, base);
    order_q.delete();
    quo_log.delete();
    rem_log.delete();
    op_a[1] = 8'd81; op_b[1] = 8'd9;
    op_a[3] = 8'd40; op_b[3] = 8'd7;
    req_on[1] = 1'b1;
    req_on[3] = 1'b1;
    force_lat = 2;
    drain();
    check("rst_ptr_first", (order_q.size() > 0) ? order_q[0] : -1, 1);
    check("rst_quo_81_9", (quo_log.size() > 0) ? 32'(quo_log[0]) : 32'hFFFF, 32'd9);
    check("rst_rem_81_9", (rem_log.size() > 0) ? 32'(rem_log[0]) : 32'hFFFF, 32'd0);

    // Randomized traffic with stray acks and operand churn.
    auto_mode = 1'b1;
    stray_en  = 1'b1;
    for (int i = 0; i < N; i++) begin
      rearm[i]       = 1'b1;
      relaunch_at[i] = cyc + 1 + i;
    end
    repeat (4000) tick();
    auto_mode = 1'b0;
    stray_en  = 1'b0;
    for (int i = 0; i < N; i++) rearm[i] = 1'b0;
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
